// File: rtl/booth_r4_seq.sv
// Sequential radix-4 Booth multiplier.
// Processes one Booth digit per clock and produces a 2*WIDTH-bit product
// that is exact for both signed and unsigned operands.
module booth_r4_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  // Number of Booth digits needed to cover WIDTH+2 extended multiplier bits.
  localparam int NDIG = WIDTH/2 + 1;
  // Operand width after the 2-bit sign/zero extension.
  localparam int XW   = WIDTH + 2;
  // Accumulator width: wide enough that a shifted partial product never wraps
  // into the product bits.
  localparam int AW   = 2*WIDTH + 4;
  localparam int IW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [XW-1:0]   m_r;      // extended multiplicand
  logic [XW:0]     scan_r;   // multiplier scan vector, shifted right two bits per digit
  logic [AW-1:0]   acc_r;    // running product
  logic [IW-1:0]   idx_r;    // current digit index

  logic [AW-1:0]   m_ext_s;
  logic [AW-1:0]   pp_s;
  logic [IW:0]     sh_s;
  logic [AW-1:0]   acc_nxt_s;
  logic [1:0]      ext1_s;
  logic [1:0]      ext2_s;

  // Extension bits for the operands being captured: sign copies or zeros.
  always_comb begin
    if (is_signed) begin
      ext1_s = {2{in1[WIDTH-1]}};
      ext2_s = {2{in2[WIDTH-1]}};
    end else begin
      ext1_s = 2'b00;
      ext2_s = 2'b00;
    end
  end

  // Decode the current overlapping 3-bit group into a partial product and
  // add it, weighted by 4^idx, to the accumulator.
  always_comb begin
    m_ext_s = {{(AW-XW){m_r[XW-1]}}, m_r};
    case (scan_r[2:0])
      3'b001, 3'b010: pp_s = m_ext_s;
      3'b011:         pp_s = m_ext_s << 1;
      3'b100:         pp_s = {AW{1'b0}} - (m_ext_s << 1);
      3'b101, 3'b110: pp_s = {AW{1'b0}} - m_ext_s;
      default:        pp_s = {AW{1'b0}};
    endcase
    sh_s      = {idx_r, 1'b0};
    acc_nxt_s = acc_r + (pp_s << sh_s);
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      m_r     <= {XW{1'b0}};
      scan_r  <= {(XW+1){1'b0}};
      acc_r   <= {AW{1'b0}};
      idx_r   <= {IW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_r     <= {ext1_s, in1};
            scan_r  <= {ext2_s, in2, 1'b0};
            acc_r   <= {AW{1'b0}};
            idx_r   <= {IW{1'b0}};
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy    <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_r  <= acc_nxt_s;
          scan_r <= {2'b00, scan_r[XW:2]};
          idx_r  <= idx_r + IW'(1);
          if (idx_r == IW'(NDIG - 1)) begin
            result  <= acc_nxt_s[2*WIDTH-1:0];
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            done    <= 1'b0;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq.sv
// Self-checking bench for booth_r4_seq: directed vector table, randomized
// products against an arithmetic reference, and multi-cycle corner sequences.
module tb_booth_r4_seq;

  localparam int W     = 32;
  localparam int NDIG  = W/2 + 1;
  localparam int NDIG8 = 8/2 + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, is_signed;
  logic [31:0]   in1, in2;
  logic          busy, done;
  logic [63:0]   result;

  logic          start8, signed8;
  logic [7:0]    a8, b8;
  logic          busy8, done8;
  logic [15:0]   res8;

  int            checks = 0;
  int            errors = 0;
  logic [63:0]   last_res;

  booth_r4_seq #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .in1(in1), .in2(in2), .busy(busy), .done(done), .result(result)
  );

  booth_r4_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(signed8),
    .in1(a8), .in2(b8), .busy(busy8), .done(done8), .result(res8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: extend both operands to the product width and multiply.
  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref_mul8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb;
    ea = sgn ? {{8{a[7]}}, a} : {8'h0, a};
    eb = sgn ? {{8{b[7]}}, b} : {8'h0, b};
    return ea * eb;
  endfunction

  // Wait (bounded) for done; result must hold its previous value meanwhile.
  task automatic wait_done(output logic [63:0] r, output int lat);
    lat = 0;
    r   = 64'h0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        r = result;
        break;
      end
      chk("result_hold", result, last_res);
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // One full multiply from IDLE; operands scrambled right after acceptance.
  task automatic run_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] r, output int lat);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; in1 = a; in2 = b;
    @(posedge clk); #1;
    start = 1'b0; in1 = $urandom; in2 = $urandom; is_signed = ~sgn;
    wait_done(r, lat);
    last_res = r;
    @(posedge clk); #1;
    chk("done_pulse_width", {63'h0, done}, 64'd0);
    chk("busy_after_done", {63'h0, busy}, 64'd0);
  endtask

  initial begin
    vec_t        vt[8];
    logic [63:0] r;
    int          lat, cyc, n_done;
    logic        sg;
    logic [31:0] a, b;
    logic [7:0]  corners[4];
    logic [7:0]  x8, y8;
    int          lat8;

    vt[0] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
    vt[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vt[2] = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vt[3] = '{1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vt[4] = '{1'b1, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB};
    vt[5] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
    vt[6] = '{1'b0, 32'h00000006, 32'h00000007, 64'h000000000000002A};
    vt[7] = '{1'b0, 32'h00000000, 32'hDEADBEEF, 64'h0000000000000000};
    corners[0] = 8'h00; corners[1] = 8'h7F; corners[2] = 8'h80; corners[3] = 8'hFF;

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; in1 = 32'h0; in2 = 32'h0;
    start8 = 1'b0; signed8 = 1'b0; a8 = 8'h0; b8 = 8'h0;
    last_res = 64'h0;
    #1;
    chk("reset_busy", {63'h0, busy}, 64'd0);
    chk("reset_done", {63'h0, done}, 64'd0);
    chk("reset_result", result, 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Directed vector table (back-to-back runs, each started the cycle busy falls).
    for (int i = 0; i < 8; i++) begin
      run_mul(vt[i].sgn, vt[i].a, vt[i].b, r, lat);
      chk($sformatf("vec%0d_result", i), r, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NDIG));
    end

    // Randomized products against the arithmetic reference.
    for (int i = 0; i < 300; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      if (i % 10 == 0) a = 32'h80000000;
      run_mul(sg, a, b, r, lat);
      chk("rand_result", r, ref_mul(sg, a, b));
    end

    // start held high with changing operands: one done, first operands only.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b1; in1 = 32'd7; in2 = 32'hFFFFFFFD;
    @(posedge clk); #1;
    n_done = 0; cyc = 0; r = 64'h0;
    while (busy && cyc < 100) begin
      in1 = $urandom; in2 = $urandom; is_signed = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        n_done++;
        r = result;
        last_res = result;
      end else begin
        chk("held_start_hold", result, last_res);
      end
    end
    chk("held_start_done_count", 64'(n_done), 64'd1);
    chk("held_start_result", r, 64'hFFFFFFFFFFFFFFEB);
    chk("held_start_busy_fall", 64'(cyc), 64'(NDIG + 1));
    is_signed = 1'b0; in1 = 32'd5; in2 = 32'd5;
    @(posedge clk); #1;
    chk("held_start_second_accept", {63'h0, busy}, 64'd1);
    start = 1'b0;
    wait_done(r, lat);
    chk("held_start_second_result", r, 64'd25);
    last_res = r;
    @(posedge clk); #1;

    // Reset mid-RUN aborts the product asynchronously.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; in1 = 32'h12345678; in2 = 32'h9ABCDEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'h0, busy}, 64'd0);
    chk("abort_done", {63'h0, done}, 64'd0);
    chk("abort_result", result, 64'h0);
    last_res = 64'h0;
    @(negedge clk); rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("abort_no_done", 64'(n_done), 64'd0);
    run_mul(1'b0, 32'd6, 32'd7, r, lat);
    chk("after_abort_result", r, 64'd42);
    chk("after_abort_latency", 64'(lat), 64'(NDIG));

    // WIDTH=8 instance: corner pairs in both modes plus random pairs.
    for (int i = 0; i < 1200; i++) begin
      if (i < 32) begin
        x8 = corners[i % 4];
        y8 = corners[(i / 4) % 4];
        sg = (i >= 16);
      end else begin
        x8 = 8'($urandom);
        y8 = 8'($urandom);
        sg = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      start8 = 1'b1; signed8 = sg; a8 = x8; b8 = y8;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat8 = 0;
      while (!done8 && lat8 < 20) begin
        @(posedge clk); #1;
        lat8++;
      end
      chk("w8_result", 64'(res8), 64'(ref_mul8(sg, x8, y8)));
      if (i < 32) chk("w8_latency", 64'(lat8), 64'(NDIG8));
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
